hwpe_stream_sink_job_scheduler: RTL
===================================

// Module: hwpe_stream_sink_job_scheduler
// PURPOSE
//  Queues sink-streamer jobs (opaque control words) issued by the HWPE controller and
//  dispatches them one at a time to a single sink streamer via its req_start/ready_start/done
//  flags. Holds the control word stable for the whole job, counts completed jobs, flags
//  queue drain and watchdog timeouts. Sits between the control FSM and the sink's ctrl/flags.
// PARAMETERS
//  JOB_WIDTH      128  width of one job descriptor (sink control word, passed through untouched)
//  JOB_DEPTH      4    job queue entries (>=1)
//  CNT_WIDTH      16   width of completed-job counter (wraps at 2^CNT_WIDTH)
//  TIMEOUT_CYCLES 0    watchdog limit in WAIT_DONE cycles; 0 disables the watchdog
// PORTS
//  clk_i              in   1                    clock
//  rst_i              in   1                    synchronous, active-high reset
//  clear_i            in   1                    synchronous soft clear, same effect as rst_i
//  job_valid_i        in   1                    job push request
//  job_i              in   JOB_WIDTH            job descriptor
//  job_ready_o        out  1                    queue can accept a job
//  sink_ctrl_o        out  JOB_WIDTH            control word to sink streamer
//  sink_req_start_o   out  1                    start request to sink
//  sink_ready_start_i in   1                    sink idle and ready to start
//  sink_done_i        in   1                    sink done pulse (1 cycle)
//  busy_o             out  1                    job in flight or queue non-empty
//  nb_jobs_o          out  $clog2(JOB_DEPTH+1)  queued (not yet dispatched) jobs
//  done_cnt_o         out  CNT_WIDTH            completed jobs since reset/clear
//  evt_drain_o        out  1                    1-cycle pulse: last queued job completed
//  error_o            out  1                    sticky watchdog timeout
// BEHAVIOUR
//  Reset/clear: queue empty, FSM IDLE, all outputs 0 except job_ready_o=1; sink_ctrl_o='0.
//  Queue: FIFO; push on job_valid_i & job_ready_o; job_ready_o = (nb_jobs_o < JOB_DEPTH).
//   Push when full is not accepted and not lost by the queue (producer must hold). Push and
//   pop in same cycle allowed: occupancy unchanged. Occupancy excludes the in-flight job.
//  FSM states IDLE, START, WAIT_DONE:
//   IDLE: if queue non-empty & ~error_o: pop head into sink_ctrl_o register -> START (1 cycle).
//    A job pushed into an empty queue is dispatched earliest the cycle after the push.
//   START: sink_req_start_o=1 (combinational from state); sink_ctrl_o stable.
//    If sink_ready_start_i=1 this cycle -> WAIT_DONE; else remain START (req held).
//   WAIT_DONE: sink_req_start_o=0; sink_ctrl_o held. On sink_done_i: done_cnt_o+1 (wrap),
//    -> IDLE; if queue empty and no push that cycle, evt_drain_o=1 next cycle.
//  sink_done_i in IDLE/START is ignored (no count, no event).
//  sink_ctrl_o only changes on dispatch; it keeps the last job's word after completion.
//  busy_o = (state != IDLE) | (nb_jobs_o != 0).
//  Watchdog (TIMEOUT_CYCLES>0): counter cleared on entry to WAIT_DONE, +1 per WAIT_DONE
//   cycle without sink_done_i; reaching TIMEOUT_CYCLES sets error_o (sticky until rst/clear).
//   FSM stays in WAIT_DONE; a late done still completes the job; no further dispatch while
//   error_o=1 (queue keeps accepting until full).
//  Back-to-back: done cycle N -> IDLE N+1 -> START N+2; minimum 3 cycles between starts.
//  rst_i/clear_i mid-job: queue and in-flight job dropped immediately, req deasserted next cycle.
// TESTING
//  T1 single job: push J=0xA5.., sink ready -> req_start 1 cycle after dispatch, done ->
//     done_cnt_o=1, evt_drain_o pulses once, busy_o=0.
//  T2 fill: push 5 jobs with JOB_DEPTH=4, sink stalled in START -> job 1 dispatched, 4 queued,
//     job_ready_o=0 until job 2 popped; all 5 complete in order, done_cnt_o=5, one evt pulse.
//  T3 ready_start low 10 cycles -> req_start_o held 10+1 cycles, sink_ctrl_o unchanged.
//  T4 simultaneous push+pop with 2 queued -> nb_jobs_o stays 2; spurious done in IDLE -> no count.
//  T5 TIMEOUT_CYCLES=8, no done -> error_o=1 after 8 WAIT_DONE cycles, no new dispatch;
//     late done -> done_cnt_o+1; clear_i -> error_o=0, queue empty.
//  T6 CNT_WIDTH=4: 17 jobs -> done_cnt_o=1; rst_i in WAIT_DONE -> all outputs at reset values.

Source files
------------

// File: rtl/hwpe_stream_sink_job_scheduler_if.sv
// Job scheduler bus: the job push handshake from the HWPE controller and the
// control/flag handshake towards a single sink streamer. Signal suffixes are
// given from the scheduler's point of view (slave modport).
interface hwpe_stream_sink_job_scheduler_if #(
    parameter int unsigned JOB_WIDTH = 128
) ();

    // Job push side (controller -> scheduler)
    logic                 job_valid_i;
    logic [JOB_WIDTH-1:0] job_i;
    logic                 job_ready_o;

    // Sink streamer side (scheduler <-> sink)
    logic [JOB_WIDTH-1:0] sink_ctrl_o;
    logic                 sink_req_start_o;
    logic                 sink_ready_start_i;
    logic                 sink_done_i;

    // Scheduler view
    modport slave (
        input  job_valid_i,
        input  job_i,
        output job_ready_o,
        output sink_ctrl_o,
        output sink_req_start_o,
        input  sink_ready_start_i,
        input  sink_done_i
    );

    // Environment view: controller pushing jobs and sink answering the flags
    modport master (
        output job_valid_i,
        output job_i,
        input  job_ready_o,
        input  sink_ctrl_o,
        input  sink_req_start_o,
        output sink_ready_start_i,
        output sink_done_i
    );

endinterface

// File: rtl/hwpe_stream_sink_job_scheduler.sv
// Sink job scheduler: buffers opaque sink control words in a small FIFO and
// dispatches them one at a time to a single sink streamer using the
// req_start / ready_start / done flag protocol. The control word of the job in
// flight is held stable in a register for the whole job. Completed jobs are
// counted, a pulse marks the completion of the last queued job and an optional
// watchdog flags a sink that never reports done.
module hwpe_stream_sink_job_scheduler #(
    parameter  int unsigned JOB_WIDTH      = 128,
    parameter  int unsigned JOB_DEPTH      = 4,
    parameter  int unsigned CNT_WIDTH      = 16,
    parameter  int unsigned TIMEOUT_CYCLES = 0,
    localparam int unsigned NB_WIDTH       = $clog2(JOB_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,

    hwpe_stream_sink_job_scheduler_if.slave job_if,

    output logic                 busy_o,
    output logic [NB_WIDTH-1:0]  nb_jobs_o,
    output logic [CNT_WIDTH-1:0] done_cnt_o,
    output logic                 evt_drain_o,
    output logic                 error_o
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int unsigned PTR_WIDTH = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1;
    localparam int unsigned WD_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(JOB_DEPTH - 1);
    localparam logic [NB_WIDTH-1:0]  NB_FULL  = NB_WIDTH'(JOB_DEPTH);
    localparam logic [WD_WIDTH-1:0]  WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

    // Dispatch FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [JOB_WIDTH-1:0] fifo_q [JOB_DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
    logic [NB_WIDTH-1:0]  count_q,    count_d;

    logic [1:0]           state_q,    state_d;
    logic [JOB_WIDTH-1:0] ctrl_q,     ctrl_d;

    logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;
    logic                 evt_q,      evt_d;
    logic                 error_q,    error_d;
    logic [WD_WIDTH-1:0]  wd_q,       wd_d;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic job_ready;
    logic push;
    logic pop;
    logic start_fire;
    logic done_fire;

    // Queue accepts while not full; a refused push stays with the producer.
    assign job_ready  = (count_q < NB_FULL);
    assign push       = job_if.job_valid_i & job_ready;

    // Dispatch only from IDLE, from a non-empty queue, and never after a
    // watchdog error. Using the registered occupancy means a job pushed into
    // an empty queue is dispatched at the earliest one cycle later.
    assign pop        = (state_q == ST_IDLE) & (count_q != '0) & ~error_q;

    assign start_fire = (state_q == ST_START) & job_if.sink_ready_start_i;

    // Done pulses outside WAIT_DONE are ignored.
    assign done_fire  = (state_q == ST_WAIT_DONE) & job_if.sink_done_i;

    // Circular pointer increment that also works for non power-of-two depths.
    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return '0;
        end
        return ptr + PTR_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // Job queue
    // ------------------------------------------------------------------

    // Store accepted job words; storage needs no reset since occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= job_if.job_i;
        end
    end

    // Advance pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + NB_WIDTH'(1);
            2'b01:   count_d = count_q - NB_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------

    // Sequence each job through dispatch, start request and completion wait.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    ctrl_d  = fifo_q[rd_ptr_q];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (job_if.sink_ready_start_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (job_if.sink_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Completion bookkeeping
    // ------------------------------------------------------------------

    // Count completions and flag the one that leaves the scheduler fully drained.
    always_comb begin
        done_cnt_d = done_cnt_q;
        evt_d      = 1'b0;
        if (done_fire) begin
            done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
            evt_d      = (count_q == '0) & ~push;
        end
    end

    // Watchdog: count WAIT_DONE cycles without done and latch a sticky error at the limit.
    always_comb begin
        wd_d    = wd_q;
        error_d = error_q;
        if (TIMEOUT_CYCLES > 0) begin
            if (start_fire) begin
                wd_d = '0;
            end else if ((state_q == ST_WAIT_DONE) && !job_if.sink_done_i && (wd_q != WD_LIMIT)) begin
                wd_d = wd_q + WD_WIDTH'(1);
                if (wd_d == WD_LIMIT) begin
                    error_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Reset and soft clear both drop the queue and any job in flight immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            done_cnt_q <= '0;
            evt_q      <= 1'b0;
            error_q    <= 1'b0;
            wd_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            done_cnt_q <= done_cnt_d;
            evt_q      <= evt_d;
            error_q    <= error_d;
            wd_q       <= wd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign job_if.job_ready_o      = job_ready;
    assign job_if.sink_ctrl_o      = ctrl_q;
    assign job_if.sink_req_start_o = (state_q == ST_START);

    assign busy_o      = (state_q != ST_IDLE) | (count_q != '0);
    assign nb_jobs_o   = count_q;
    assign done_cnt_o  = done_cnt_q;
    assign evt_drain_o = evt_q;
    assign error_o     = error_q;

endmodule
